// File: rtl/tx_axis_arbiter.sv
// Packet-locked two-port round-robin arbiter feeding the Tx FIFO write port.
// Optional stall watchdog is built only when TX_ARB_WATCHDOG_EN is defined.
module tx_axis_arbiter #(
  parameter int data_width = 64,
  parameter int keep_width = 8,
  parameter int wd_cycles  = 256
) (
  input  logic                  tx_arb_clk,
  input  logic                  tx_arb_reset,
  input  logic [data_width-1:0] tx_arb_s0_data,
  input  logic [keep_width-1:0] tx_arb_s0_keep,
  input  logic                  tx_arb_s0_valid,
  input  logic                  tx_arb_s0_last,
  output logic                  tx_arb_s0_ready,
  input  logic [data_width-1:0] tx_arb_s1_data,
  input  logic [keep_width-1:0] tx_arb_s1_keep,
  input  logic                  tx_arb_s1_valid,
  input  logic                  tx_arb_s1_last,
  output logic                  tx_arb_s1_ready,
  output logic [data_width-1:0] tx_fifo_data,
  output logic [keep_width-1:0] tx_fifo_keep,
  output logic                  tx_fifo_valid,
  output logic                  tx_fifo_last,
  input  logic                  tx_fifo_ready,
  output logic [1:0]            tx_arb_grant,
  output logic                  tx_arb_timeout
);

  // state | meaning
  // IDLE  | no grant, one bubble between packets while arbitrating
  // GNT0  | port 0 owns the FIFO write port until its last beat is taken
  // GNT1  | port 1 owns the FIFO write port until its last beat is taken
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t state, state_next;
  logic   last_gnt;
  logic   wd_fire;

  if (wd_cycles < 1) begin : g_bad_wd
    $error("wd_cycles must be at least 1");
  end
  if (keep_width * 8 != data_width) begin : g_bad_keep
    $error("keep_width must equal data_width/8");
  end

`ifdef TX_ARB_WATCHDOG_EN
  localparam int wd_w = $clog2(wd_cycles + 1);
  logic [wd_w-1:0] wd_cnt;
  logic            gnt_valid;
  logic            timeout_q;

  // Down-counter reloads on any valid beat; terminal count on the final low cycle.
  assign gnt_valid = (state == GNT1) ? tx_arb_s1_valid : tx_arb_s0_valid;
  assign wd_fire   = (state != IDLE) && !gnt_valid && (wd_cnt == wd_w'(1));

  always_ff @(posedge tx_arb_clk) begin
    if (tx_arb_reset) begin
      wd_cnt    <= wd_w'(wd_cycles);
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_fire;
      if (state == IDLE || gnt_valid)
        wd_cnt <= wd_w'(wd_cycles);
      else if (wd_cnt != '0)
        wd_cnt <= wd_cnt - 1'b1;
    end
  end

  assign tx_arb_timeout = timeout_q;
`else
  assign wd_fire        = 1'b0;
  assign tx_arb_timeout = 1'b0;
`endif

  always_ff @(posedge tx_arb_clk) begin
    if (tx_arb_reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == GNT0)
        last_gnt <= 1'b0;
      else if (state == IDLE && state_next == GNT1)
        last_gnt <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (tx_arb_s0_valid && tx_arb_s1_valid)
          state_next = last_gnt ? GNT0 : GNT1;
        else if (tx_arb_s0_valid)
          state_next = GNT0;
        else if (tx_arb_s1_valid)
          state_next = GNT1;
      end
      GNT0: if (tx_arb_s0_valid && tx_fifo_ready && tx_arb_s0_last) state_next = IDLE;
      GNT1: if (tx_arb_s1_valid && tx_fifo_ready && tx_arb_s1_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (wd_fire)
      state_next = IDLE;
  end

  always_comb begin
    tx_fifo_data    = '0;
    tx_fifo_keep    = '0;
    tx_fifo_valid   = 1'b0;
    tx_fifo_last    = 1'b0;
    tx_arb_s0_ready = 1'b0;
    tx_arb_s1_ready = 1'b0;
    tx_arb_grant    = 2'b00;
    case (state)
      GNT0: begin
        tx_fifo_data    = tx_arb_s0_data;
        tx_fifo_keep    = tx_arb_s0_keep;
        tx_fifo_valid   = tx_arb_s0_valid;
        tx_fifo_last    = tx_arb_s0_last;
        tx_arb_s0_ready = tx_fifo_ready;
        tx_arb_grant    = 2'b01;
      end
      GNT1: begin
        tx_fifo_data    = tx_arb_s1_data;
        tx_fifo_keep    = tx_arb_s1_keep;
        tx_fifo_valid   = tx_arb_s1_valid;
        tx_fifo_last    = tx_arb_s1_last;
        tx_arb_s1_ready = tx_fifo_ready;
        tx_arb_grant    = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Scoreboard bench for tx_axis_arbiter: drivers push expected beats, a monitor
// pops and compares every beat the Tx FIFO accepts.
module tb_tx_axis_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] s0_data, s1_data;
  logic [7:0]  s0_keep, s1_keep;
  logic        s0_valid, s1_valid, s0_last, s1_last;
  logic        s0_ready, s1_ready;
  logic [63:0] f_data;
  logic [7:0]  f_keep;
  logic        f_valid, f_last, f_ready;
  logic [1:0]  grant;
  logic        timeout;

  always #5 clk = ~clk;

  tx_axis_arbiter #(.data_width(64), .keep_width(8), .wd_cycles(16)) dut (
    .tx_arb_clk      (clk),
    .tx_arb_reset    (reset),
    .tx_arb_s0_data  (s0_data),
    .tx_arb_s0_keep  (s0_keep),
    .tx_arb_s0_valid (s0_valid),
    .tx_arb_s0_last  (s0_last),
    .tx_arb_s0_ready (s0_ready),
    .tx_arb_s1_data  (s1_data),
    .tx_arb_s1_keep  (s1_keep),
    .tx_arb_s1_valid (s1_valid),
    .tx_arb_s1_last  (s1_last),
    .tx_arb_s1_ready (s1_ready),
    .tx_fifo_data    (f_data),
    .tx_fifo_keep    (f_keep),
    .tx_fifo_valid   (f_valid),
    .tx_fifo_last    (f_last),
    .tx_fifo_ready   (f_ready),
    .tx_arb_grant    (grant),
    .tx_arb_timeout  (timeout)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  int    order_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    to_cnt = 0;
  bit    cur_open = 1'b0;
  int    cur_port = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Called at a falling edge; returns at the falling edge after the beat is taken.
  task automatic put_beat(input int port, input logic [63:0] d, input logic [7:0] k, input logic l);
    beat_t b;
    int n;
    b.d = d; b.k = k; b.l = l;
    if (port == 0) begin
      s0_valid = 1'b1; s0_data = d; s0_keep = k; s0_last = l; q0.push_back(b);
    end else begin
      s1_valid = 1'b1; s1_data = d; s1_keep = k; s1_last = l; q1.push_back(b);
    end
    #1;
    n = 0;
    while (!((port == 0) ? s0_ready : s1_ready)) begin
      @(negedge clk); #1;
      n++;
      if (n > 64) begin
        n_checks++;
        $display("FAIL accept_wait port%0d: beat %0h not accepted within 64 cycles", port, d);
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_pkt(input int port, input int len, input logic [63:0] base);
    for (int i = 0; i < len; i++)
      put_beat(port, base + 64'(i), (i == len - 1) ? 8'h0F : 8'hFF, i == len - 1);
    if (port == 0) begin s0_valid = 1'b0; s0_last = 1'b0; end
    else begin s1_valid = 1'b0; s1_last = 1'b0; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  initial forever begin
    @(negedge clk); #2;
    if (timeout) to_cnt++;
  end

  // Monitor: every accepted beat must come from the packet currently owning the port.
  initial forever begin
    beat_t b;
    @(negedge clk); #2;
    if (reset || timeout) begin
      cur_open = 1'b0;
    end else if (f_valid && f_ready) begin
      if (!cur_open) begin
        check("order_q_nonempty", 64'(order_q.size() != 0), 64'd1);
        if (order_q.size() != 0) cur_port = order_q.pop_front();
        cur_open = 1'b1;
      end
      check("grant", 64'(grant), (cur_port == 0) ? 64'd1 : 64'd2);
      if (cur_port == 0) begin
        check("beat_q0_nonempty", 64'(q0.size() != 0), 64'd1);
        if (q0.size() != 0) b = q0.pop_front();
      end else begin
        check("beat_q1_nonempty", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0) b = q1.pop_front();
      end
      check("data", f_data, b.d);
      check("keep", 64'(f_keep), 64'(b.k));
      check("last", 64'(f_last), 64'(b.l));
      if (f_last) cur_open = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; f_ready = 1'b1;
    s0_valid = 0; s0_data = 0; s0_keep = 0; s0_last = 0;
    s1_valid = 0; s1_data = 0; s1_keep = 0; s1_last = 0;
    @(negedge clk); @(negedge clk);
    #3;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_s0_ready", 64'(s0_ready), 64'd0);
    check("rst_s1_ready", 64'(s1_ready), 64'd0);
    check("rst_fifo_valid", 64'(f_valid), 64'd0);
    check("rst_fifo_data", f_data, 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single 3-beat packet on port 0.
    order_q.push_back(0);
    fork
      send_pkt(0, 3, 64'h1000);
      begin
        #3 check("t1_grant_before", 64'(grant), 64'd0);
        @(negedge clk); #3 check("t1_grant_after", 64'(grant), 64'd1);
      end
    join
    #3 check("t1_back_idle", 64'(grant), 64'd0);
    @(negedge clk);

    // Simultaneous 2-beat packets out of reset: port 0 first, one bubble, then port 1.
    do_reset();
    @(negedge clk);
    order_q.push_back(0); order_q.push_back(1);
    fork
      send_pkt(0, 2, 64'h2000);
      send_pkt(1, 2, 64'h2100);
      begin
        #3 check("t2_g0", 64'(grant), 64'd0);
        @(negedge clk); #3 check("t2_g1", 64'(grant), 64'd1);
        @(negedge clk); #3 check("t2_g2", 64'(grant), 64'd1);
        @(negedge clk); #3 check("t2_bubble", 64'(grant), 64'd0);
        @(negedge clk); #3 check("t2_g4", 64'(grant), 64'd2);
      end
    join
    @(negedge clk);

    // Port 1 streams 1-beat packets; port 0 joins and gets the next slot.
    order_q.push_back(1); order_q.push_back(0);
    order_q.push_back(1); order_q.push_back(1);
    fork
      begin
        send_pkt(1, 1, 64'h3100);
        send_pkt(1, 1, 64'h3101);
        send_pkt(1, 1, 64'h3102);
      end
      begin
        @(negedge clk);
        send_pkt(0, 1, 64'h3000);
      end
    join
    @(negedge clk);

    // FIFO backpressure for 5 cycles on beat 2.
    order_q.push_back(0);
    fork
      send_pkt(0, 3, 64'h4000);
      begin
        @(negedge clk); @(negedge clk);
        f_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          #3;
          check("t4_s0_ready_low", 64'(s0_ready), 64'd0);
          check("t4_data_held", f_data, 64'h4001);
          @(negedge clk);
        end
        f_ready = 1'b1;
      end
    join
    @(negedge clk);

    // Reset on beat 2 of a port-1 packet.
    order_q.push_back(1);
    put_beat(1, 64'h5000, 8'hFF, 1'b0);
    s1_data = 64'h5001;
    reset = 1'b1;
    @(negedge clk); #3;
    check("t5_grant", 64'(grant), 64'd0);
    check("t5_fifo_valid", 64'(f_valid), 64'd0);
    check("t5_s1_ready", 64'(s1_ready), 64'd0);
    reset = 1'b0; s1_valid = 1'b0; s1_last = 1'b0;
    @(negedge clk);
    order_q.push_back(0); order_q.push_back(1);
    fork
      send_pkt(0, 1, 64'h5100);
      send_pkt(1, 1, 64'h5200);
    join
    @(negedge clk);

    // Port 0 stalls mid-packet.
    to_cnt = 0;
    order_q.push_back(0);
    put_beat(0, 64'h6000, 8'hFF, 1'b0);
    s0_valid = 1'b0;
`ifdef TX_ARB_WATCHDOG_EN
    order_q.push_back(1);
    fork
      send_pkt(1, 1, 64'h6100);
      begin
        repeat (16) @(negedge clk);
        #3;
        check("t6_wd_grant_idle", 64'(grant), 64'd0);
        check("t6_wd_pulse", 64'(timeout), 64'd1);
        @(negedge clk); #3;
        check("t6_wd_grant_p1", 64'(grant), 64'd2);
      end
    join
    repeat (3) @(negedge clk);
    check("t6_wd_pulse_count", 64'(to_cnt), 64'd1);
`else
    repeat (20) @(negedge clk);
    #3;
    check("t6_grant_held", 64'(grant), 64'd1);
    check("t6_no_timeout", 64'(to_cnt), 64'd0);
    @(negedge clk);
    put_beat(0, 64'h6001, 8'h0F, 1'b1);
    s0_valid = 1'b0; s0_last = 1'b0;
`endif
    repeat (3) @(negedge clk);

    check("end_order_q_empty", 64'(order_q.size()), 64'd0);
    check("end_q0_empty", 64'(q0.size()), 64'd0);
    check("end_q1_empty", 64'(q1.size()), 64'd0);
    check("end_no_open_pkt", 64'(cur_open), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_axis_arbiter.md
# tx_axis_arbiter

Two-port, packet-locked round-robin arbiter that shares the single Tx header/data FIFO write port between the completion generator (port 0) and the message/error generator (port 1). It sits in the Tx path ahead of the Tx AXI FIFO. Once a port is granted, it forwards that port's AXI-stream beats unmodified until the beat carrying `last` is accepted, so packets never interleave.

## Interface
Parameters:
- `data_width`, 64: AXI data width per beat.
- `keep_width`, 8: byte-enable width, `data_width/8`.
- `wd_cycles`, 256: watchdog stall limit in cycles. Used only with `TX_ARB_WATCHDOG_EN`.

Ports:
- `tx_arb_clk`: input, 1, the single clock.
- `tx_arb_reset`: input, 1, synchronous, active-high reset.
- `tx_arb_s0_data` / `tx_arb_s1_data`: input, data_width, source payload.
- `tx_arb_s0_keep` / `tx_arb_s1_keep`: input, keep_width, source byte enables.
- `tx_arb_s0_valid` / `tx_arb_s1_valid`: input, 1, source beat valid.
- `tx_arb_s0_last` / `tx_arb_s1_last`: input, 1, final beat of the packet.
- `tx_arb_s0_ready` / `tx_arb_s1_ready`: output, 1, beat accepted from the source.
- `tx_fifo_data`: output, data_width, to the Tx FIFO.
- `tx_fifo_keep`: output, keep_width, to the Tx FIFO.
- `tx_fifo_valid`: output, 1, to the Tx FIFO.
- `tx_fifo_last`: output, 1, to the Tx FIFO.
- `tx_fifo_ready`: input, 1, Tx FIFO can accept a beat.
- `tx_arb_grant`: output, 2, one-hot current grant; `00` when idle.
- `tx_arb_timeout`: output, 1, one-cycle watchdog pulse.

## Operation
- States: `IDLE`, `GNT0`, `GNT1`. A registered `last_gnt` bit records which port was granted most recently.
- `IDLE`, with only sN_valid high: next state is `GNTN`.
- `IDLE`, with both valid: grant the port that is not `last_gnt`.
- `IDLE`, with neither valid: stay in `IDLE`.
- Entering `GNTN` sets `last_gnt` to N.
- `GNTN` forwarding is combinational:
  - `tx_fifo_{data,keep,last,valid}` equal the sN signals.
  - `tx_arb_sN_ready` equals `tx_fifo_ready`.
  - The other port's ready is 0.
- `GNTN`, on `tx_arb_sN_valid && tx_fifo_ready && tx_arb_sN_last`: return to `IDLE`.
- `GNTN`, otherwise: stay in `GNTN`. Valid gaps inside a packet do not release the grant.
- In `IDLE`:
  - Both source readies are 0.
  - `tx_fifo_valid` is 0.
  - `tx_fifo_data`, `tx_fifo_keep` and `tx_fifo_last` are driven to 0.
- `tx_arb_grant` is decoded from state: `GNT0` gives `01`, `GNT1` gives `10`.
- No data is stored or modified. Keep and last pass through bit-exact.

## Timing
- Reset values:
  - State is `IDLE`.
  - `last_gnt` is 1, so port 0 wins the first tie.
  - All readies are 0, `tx_fifo_valid` is 0, `tx_arb_grant` is `00`, `tx_arb_timeout` is 0.
- Arbitration latency is one cycle. Valid sampled in `IDLE` at edge k gives grant and forwarding from cycle k+1.
- Each packet costs one `IDLE` bubble. Back-to-back packets achieve at most L/(L+1) throughput, where L is packet length in beats.
- A single-beat packet (valid and last together) completes in one `GNTN` cycle, then returns to `IDLE`.
- `tx_fifo_ready` low holds the current beat. Sources must hold data stable while valid is high and ready is low (AXI rule). The arbiter never drops valid once it is asserted.
- Reset asserted mid-packet: go to `IDLE` on that edge, and the packet is truncated. The Tx FIFO and both sources share `tx_arb_reset`, so no partial packet survives.
- Valid toggling while in `IDLE` has no side effect until it is sampled.

## Configuration
- `TX_ARB_WATCHDOG_EN` defined:
  - In `GNTN`, a counter counts consecutive cycles with `tx_arb_sN_valid` low. It clears on any cycle where valid is high.
  - When the count reaches `wd_cycles`:
    - Force the state to `IDLE`.
    - Pulse `tx_arb_timeout` for one cycle.
    - `last_gnt` is unchanged, so the other port is preferred next.
  - The counter resets to 0 on reset and on entering `IDLE`.
- `TX_ARB_WATCHDOG_EN` undefined:
  - No counter is built.
  - `tx_arb_timeout` is tied to 0.
  - A stalled source holds the grant indefinitely.

## Test plan
- Reset, then only port 0 sends a 3-beat packet with `tx_fifo_ready` = 1:
  - `tx_arb_grant` = `01` one cycle after valid.
  - 3 beats are output with identical data/keep.
  - `last` appears on beat 3, then the state returns to `IDLE`.
- Both ports are valid simultaneously out of reset, each with a 2-beat packet:
  - Port 0 is granted first.
  - After its last beat there is one idle cycle.
  - Port 1 is then granted. Output order is s0 beats, then s1 beats, never interleaved.
- Port 1 holds valid continuously with repeated 1-beat packets while port 0 raises valid:
  - Grants alternate `10`, `01`, `10`.
  - Neither port waits more than one packet.
- `tx_fifo_ready` held low for 5 cycles mid-packet:
  - Beat 2 is held stable on the output.
  - `tx_arb_s0_ready` = 0 for those 5 cycles.
  - The packet completes after ready returns. No beat is lost or duplicated.
- Reset asserted in `GNT1` on beat 2 of a 4-beat packet:
  - Next cycle: `IDLE`, grant `00`, `tx_fifo_valid` = 0.
  - The next arbitration favours port 0.
- With `TX_ARB_WATCHDOG_EN` and `wd_cycles` = 16, port 0 drops valid mid-packet for 16 cycles:
  - `tx_arb_timeout` pulses once.
  - The grant returns to `00`.
  - A waiting port 1 is granted on the following cycle.
  - Without the macro, the grant stays `01`.
